ksa_swap_engine: RTL and testbench

//   Parametrised RC4 key-scheduling swap loop (KSA second pass). Runs after the S-array

---
 rtl/ksa_swap_engine.sv | 189 ++++++++++++++++++
 tb/tb_ksa_swap_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_swap_engine.sv
// RC4 key-scheduling swap pass: walks i over the S-RAM, accumulates j from S[i] and the key,
// and swaps S[i]/S[j] through a single registered RAM port with configurable read latency.
module ksa_swap_engine #(
  parameter int AW         = 8,
  parameter int KEY_LEN    = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [KEY_LEN*8-1:0] i_key,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [AW-1:0]        o_addr,
  input  logic [AW-1:0]        i_rddata,
  output logic [AW-1:0]        o_wrdata,
  output logic                 o_wren
);

  localparam int DEPTH = 2 ** AW;
  localparam int KW    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int LW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [AW-1:0] LAST_I = AW'(DEPTH - 1);
  localparam logic [KW-1:0] LAST_K = KW'(KEY_LEN - 1);
  localparam logic [LW-1:0] LAST_L = LW'(RD_LATENCY - 1);

  typedef enum logic [3:0] {
    IDLE, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_J, WR_I, NEXT
  } state_t;

  state_t r_state, w_stateNxt;

  logic [KEY_LEN*8-1:0] r_key, w_keyNxt;
  logic [AW-1:0]        r_i, w_iNxt;
  logic [AW-1:0]        r_j, w_jNxt;
  logic [KW-1:0]        r_kidx, w_kidxNxt;
  logic [AW-1:0]        r_si, w_siNxt;
  logic [AW-1:0]        r_sj, w_sjNxt;
  logic [LW-1:0]        r_lat, w_latNxt;
  logic [AW-1:0]        r_addr, w_addrNxt;
  logic [AW-1:0]        r_wrdata, w_wrdataNxt;
  logic                 r_wren, w_wrenNxt;
  logic                 r_busy, w_busyNxt;
  logic                 r_done, w_doneNxt;

  logic [7:0]    w_keyByte;
  logic [AW-1:0] w_keyAw;
  logic          w_accept;
  logic          w_latLast;
  logic          w_lastIter;

  assign w_accept   = i_start && !r_busy;
  assign w_latLast  = (r_lat == LAST_L);
  assign w_lastIter = (r_i == LAST_I);

  // Key byte 0 sits in the top byte of the key; select by the wrapping kidx counter.
  always_comb begin
    w_keyByte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (r_kidx == KW'(k)) w_keyByte = r_key[KEY_LEN*8-1-8*k -: 8];
    end
  end

  assign w_keyAw = AW'(w_keyByte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_key    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_kidx   <= '0;
      r_si     <= '0;
      r_sj     <= '0;
      r_lat    <= '0;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_wren   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_key    <= w_keyNxt;
      r_i      <= w_iNxt;
      r_j      <= w_jNxt;
      r_kidx   <= w_kidxNxt;
      r_si     <= w_siNxt;
      r_sj     <= w_sjNxt;
      r_lat    <= w_latNxt;
      r_addr   <= w_addrNxt;
      r_wrdata <= w_wrdataNxt;
      r_wren   <= w_wrenNxt;
      r_busy   <= w_busyNxt;
      r_done   <= w_doneNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNxt = RD_I;
      RD_I:    w_stateNxt = WAIT_I;
      WAIT_I:  if (w_latLast) w_stateNxt = CAP_I;
      CAP_I:   w_stateNxt = RD_J;
      RD_J:    w_stateNxt = (r_j == r_i) ? NEXT : WAIT_J;
      WAIT_J:  if (w_latLast) w_stateNxt = CAP_J;
      CAP_J:   w_stateNxt = WR_J;
      WR_J:    w_stateNxt = WR_I;
      WR_I:    w_stateNxt = NEXT;
      NEXT:    w_stateNxt = w_lastIter ? IDLE : RD_I;
      default: w_stateNxt = IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    w_keyNxt    = r_key;
    w_iNxt      = r_i;
    w_jNxt      = r_j;
    w_kidxNxt   = r_kidx;
    w_siNxt     = r_si;
    w_sjNxt     = r_sj;
    w_latNxt    = r_lat;
    w_addrNxt   = r_addr;
    w_wrdataNxt = r_wrdata;
    w_wrenNxt   = r_wren;
    w_busyNxt   = r_busy;
    w_doneNxt   = r_done;
    case (r_state)
      IDLE: begin
        w_wrenNxt = 1'b0;
        if (w_accept) begin
          w_keyNxt  = i_key;
          w_iNxt    = '0;
          w_jNxt    = '0;
          w_kidxNxt = '0;
          w_doneNxt = 1'b0;
          w_busyNxt = 1'b1;
        end
      end
      RD_I: begin
        w_addrNxt = r_i;
        w_wrenNxt = 1'b0;
        w_latNxt  = '0;
      end
      WAIT_I, WAIT_J: w_latNxt = r_lat + 1'b1;
      CAP_I: begin
        w_siNxt = i_rddata;
        w_jNxt  = r_j + i_rddata + w_keyAw;
      end
      RD_J: begin
        if (r_j != r_i) begin
          w_addrNxt = r_j;
          w_latNxt  = '0;
        end
      end
      CAP_J: w_sjNxt = i_rddata;
      WR_J: begin
        w_wrenNxt   = 1'b1;
        w_addrNxt   = r_j;
        w_wrdataNxt = r_si;
      end
      WR_I: begin
        w_wrenNxt   = 1'b1;
        w_addrNxt   = r_i;
        w_wrdataNxt = r_sj;
      end
      NEXT: begin
        w_wrenNxt = 1'b0;
        if (w_lastIter) begin
          w_doneNxt = 1'b1;
          w_busyNxt = 1'b0;
          w_addrNxt = '0;
        end else begin
          w_iNxt    = r_i + 1'b1;
          w_kidxNxt = (r_kidx == LAST_K) ? '0 : r_kidx + 1'b1;
        end
      end
      default: w_wrenNxt = 1'b0;
    endcase
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_addr   = r_addr;
  assign o_wrdata = r_wrdata;
  assign o_wren   = r_wren;

endmodule

// File: tb/tb_ksa_swap_engine.sv
// Bench for ksa_swap_engine: two builds (8-bit/3-byte key/latency 2 and 4-bit/5-byte key/latency 1)
// against behavioural S-RAMs, with an RC4-KSA model feeding a queue of expected writes.
module tb_ksa_swap_engine;

  localparam int AWA = 8, KLA = 3, RLA = 2, DA = 256;
  localparam int AWB = 4, KLB = 5, RLB = 1, DB = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t qExp[$];
  int  expS [256];
  int  expCyc;

  // Build A
  logic               startA, busyA, doneA, wrenA, initA;
  logic [KLA*8-1:0]   keyA;
  logic [AWA-1:0]     addrA, rddataA, wrdataA;
  logic [AWA-1:0]     memA [DA];
  logic [AWA-1:0]     pipeA [RLA];

  ksa_swap_engine #(.AW(AWA), .KEY_LEN(KLA), .RD_LATENCY(RLA)) dutA (
    .clk(clk), .rst_n(rst_n), .i_start(startA), .i_key(keyA),
    .o_busy(busyA), .o_done(doneA), .o_addr(addrA), .i_rddata(rddataA),
    .o_wrdata(wrdataA), .o_wren(wrenA)
  );

  always @(posedge clk) begin
    if (initA) for (int k = 0; k < DA; k++) memA[k] <= AWA'(k);
    else if (wrenA) memA[addrA] <= wrdataA;
    pipeA[0] <= memA[addrA];
    for (int k = 1; k < RLA; k++) pipeA[k] <= pipeA[k-1];
  end
  assign rddataA = pipeA[RLA-1];

  // Build B
  logic               startB, busyB, doneB, wrenB, initB;
  logic [KLB*8-1:0]   keyB;
  logic [AWB-1:0]     addrB, rddataB, wrdataB;
  logic [AWB-1:0]     memB [DB];
  logic [AWB-1:0]     pipeB [RLB];

  ksa_swap_engine #(.AW(AWB), .KEY_LEN(KLB), .RD_LATENCY(RLB)) dutB (
    .clk(clk), .rst_n(rst_n), .i_start(startB), .i_key(keyB),
    .o_busy(busyB), .o_done(doneB), .o_addr(addrB), .i_rddata(rddataB),
    .o_wrdata(wrdataB), .o_wren(wrenB)
  );

  always @(posedge clk) begin
    if (initB) for (int k = 0; k < DB; k++) memB[k] <= AWB'(k);
    else if (wrenB) memB[addrB] <= wrdataB;
    pipeB[0] <= memB[addrB];
    for (int k = 1; k < RLB; k++) pipeB[k] <= pipeB[k-1];
  end
  assign rddataB = pipeB[RLB-1];

  // RC4 KSA from identity S; pushes expected writes with the busy-cycle index they appear in.
  task automatic model(input int depth, input int klen, input int rl, input logic [63:0] key);
    int s [256];
    int j = 0, c = 0, t, kb;
    logic [63:0] sh;
    qExp.delete();
    for (int k = 0; k < depth; k++) s[k] = k;
    for (int i = 0; i < depth; i++) begin
      sh = key >> ((klen - 1 - (i % klen)) * 8);
      kb = int'(sh[7:0]);
      j  = (j + s[i] + kb) % depth;
      if (j == i) begin
        c += rl + 4;
      end else begin
        qExp.push_back('{j, s[i], c + 2*rl + 6});
        qExp.push_back('{i, s[j], c + 2*rl + 7});
        t = s[i]; s[i] = s[j]; s[j] = t;
        c += 2*rl + 7;
      end
    end
    for (int k = 0; k < depth; k++) expS[k] = s[k];
    expCyc = c;
  endtask

  task automatic initMemA();
    @(negedge clk); initA = 1'b1;
    @(negedge clk); initA = 1'b0;
  endtask

  task automatic launchA(input logic [KLA*8-1:0] key);
    model(DA, KLA, RLA, 64'(key));
    @(negedge clk); startA = 1'b1; keyA = key;
    @(posedge clk); #1; startA = 1'b0; keyA = ~key;
  endtask

  // Scoreboard for build A: pops expected writes as wren appears, then checks the finished run.
  task automatic drainA(input int stopAt, input int pulseAt, input logic [KLA*8-1:0] pulseKey);
    int busyCyc = 0, t = 0, bad = 0, firstBad = -1;
    bit fin = 0, stopped = 0;
    wr_t e;
    while (!fin && t < 6000) begin
      @(negedge clk); t++;
      if (busyA) busyCyc++;
      if (busyA && busyCyc == pulseAt) begin
        startA = 1'b1; keyA = pulseKey;
      end else begin
        startA = 1'b0;
      end
      if (wrenA) begin
        checks++;
        if (qExp.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_write addr=%0h data=%0h at busy cycle %0d, none expected", addrA, wrdataA, busyCyc);
        end else begin
          e = qExp.pop_front();
          if (addrA !== AWA'(e.addr) || wrdataA !== AWA'(e.data) || busyCyc !== e.cyc)
            begin
              errors++;
              $display("[TB] FAIL write got addr=%0h data=%0h cyc=%0d exp addr=%0h data=%0h cyc=%0d",
                       addrA, wrdataA, busyCyc, e.addr, e.data, e.cyc);
            end
        end
      end
      if (busyCyc == stopAt) begin fin = 1; stopped = 1; end
      else if (!busyA) fin = 1;
    end
    if (!fin) begin
      checks++; errors++;
      $display("[TB] FAIL timeout busy still %0b after %0d cycles", busyA, t);
    end else if (!stopped) begin
      checks++;
      if (busyCyc !== expCyc) begin
        errors++; $display("[TB] FAIL run_cycles got %0d exp %0d", busyCyc, expCyc);
      end
      checks++;
      if (doneA !== 1'b1 || wrenA !== 1'b0 || addrA !== '0) begin
        errors++; $display("[TB] FAIL end_state done=%0b wren=%0b addr=%0h exp 1 0 0", doneA, wrenA, addrA);
      end
      checks++;
      if (qExp.size() != 0) begin
        errors++; $display("[TB] FAIL missing_writes got %0d left exp 0", qExp.size());
      end
      for (int k = 0; k < DA; k++) if (memA[k] !== AWA'(expS[k])) begin
        bad++; if (firstBad < 0) firstBad = k;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL final_S %0d entries differ, first S[%0h] got %0h exp %0h",
                 bad, firstBad, memA[firstBad], expS[firstBad]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; startA = 1'b0; startB = 1'b0; initA = 1'b0; initB = 1'b0;
    keyA = '0; keyB = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || wrenA !== 1'b0 || addrA !== '0 || wrdataA !== '0) begin
      errors++;
      $display("[TB] FAIL reset_A busy=%0b done=%0b wren=%0b addr=%0h wrdata=%0h exp all 0",
               busyA, doneA, wrenA, addrA, wrdataA);
    end
    checks++;
    if (busyB !== 1'b0 || doneB !== 1'b0 || wrenB !== 1'b0 || addrB !== '0) begin
      errors++; $display("[TB] FAIL reset_B busy=%0b done=%0b wren=%0b addr=%0h exp all 0", busyB, doneB, wrenB, addrB);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_first_key();
    $display("[TB] key 0A0B0C from identity");
    initMemA();
    launchA(24'h0A0B0C);
    checks++;
    if (busyA !== 1'b1 || doneA !== 1'b0) begin
      errors++; $display("[TB] FAIL accept busy=%0b done=%0b exp 1 0", busyA, doneA);
    end
    drainA(-1, -1, '0);
  endtask

  task automatic test_zero_key();
    $display("[TB] key 000000, early skips");
    initMemA();
    launchA(24'h000000);
    drainA(-1, -1, '0);
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    $display("[TB] async reset during WR_J");
    initMemA();
    launchA(24'h0A0B0C);
    drainA(9, -1, '0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (wrenA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0 || addrA !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset wren=%0b busy=%0b done=%0b addr=%0h exp all 0", wrenA, busyA, doneA, addrA);
    end
    qExp.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (wrenA !== 1'b0 || busyA !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("[TB] FAIL idle_after_reset got %0d active cycles exp 0", stray);
    end
    initMemA();
    launchA(24'h133713);
    drainA(-1, -1, '0);
  endtask

  task automatic test_busy_ignore();
    $display("[TB] start while busy, then restart after done");
    initMemA();
    launchA(24'h5A5A5A);
    drainA(-1, 50, 24'hFFFFFF);
    initMemA();
    checks++;
    if (doneA !== 1'b1) begin
      errors++; $display("[TB] FAIL done_held got %0b exp 1", doneA);
    end
    launchA(24'hC0FFEE);
    checks++;
    if (doneA !== 1'b0 || busyA !== 1'b1) begin
      errors++; $display("[TB] FAIL restart done=%0b busy=%0b exp 0 1", doneA, busyA);
    end
    drainA(-1, -1, '0);
  endtask

  task automatic test_small_build();
    logic [KLB*8-1:0] key = 40'hF1239A4C07;
    int busyCyc = 0, t = 0, bad = 0;
    wr_t e;
    $display("[TB] AW=4 KEY_LEN=5 RD_LATENCY=1 build");
    model(DB, KLB, RLB, 64'(key));
    @(negedge clk); initB = 1'b1;
    @(negedge clk); initB = 1'b0; startB = 1'b1; keyB = key;
    @(posedge clk); #1; startB = 1'b0; keyB = '0;
    checks++;
    if (busyB !== 1'b1 || doneB !== 1'b0) begin
      errors++; $display("[TB] FAIL accept_B busy=%0b done=%0b exp 1 0", busyB, doneB);
    end
    while (busyB && t < 2000) begin
      @(negedge clk); t++;
      if (busyB) busyCyc++;
      if (wrenB) begin
        checks++;
        if (qExp.size() == 0) begin
          errors++; $display("[TB] FAIL extra_write_B addr=%0h data=%0h none expected", addrB, wrdataB);
        end else begin
          e = qExp.pop_front();
          if (addrB !== AWB'(e.addr) || wrdataB !== AWB'(e.data) || busyCyc !== e.cyc) begin
            errors++;
            $display("[TB] FAIL write_B got addr=%0h data=%0h cyc=%0d exp addr=%0h data=%0h cyc=%0d",
                     addrB, wrdataB, busyCyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (busyB !== 1'b0 || doneB !== 1'b1 || busyCyc !== expCyc) begin
      errors++;
      $display("[TB] FAIL end_B busy=%0b done=%0b cycles=%0d exp 0 1 %0d", busyB, doneB, busyCyc, expCyc);
    end
    checks++;
    if (qExp.size() != 0) begin
      errors++; $display("[TB] FAIL missing_writes_B got %0d left exp 0", qExp.size());
    end
    for (int k = 0; k < DB; k++) if (memB[k] !== AWB'(expS[k])) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL final_S_B got %0d differing entries exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_first_key();
    test_zero_key();
    test_mid_reset();
    test_busy_ignore();
    test_small_build();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
